// File: rtl/unified_mem_if.sv
// Request/response bundle between the core's fetch and data ports and unified_mem_pipe.
// The memory takes the slave modport; the core (or a bench) takes the master modport.
interface unified_mem_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, d_err, conflict_cnt
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, d_err, conflict_cnt
    );
endinterface

// File: rtl/unified_mem_pipe.sv
// Single-ported byte-addressable memory shared by instruction fetch and data load/store.
// Data has priority over fetch; responses come back READ_LAT (1 or 2) cycles after acceptance.
module unified_mem_pipe #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    unified_mem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];

    logic              d_acc;
    logic              if_acc;
    logic              d_err_c;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_word;
    logic [31:0]       d_rdata_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              d_vld_p0_q;
    logic              d_err_p0_q;
    logic [31:0]       d_rdata_p0_q;
    logic              if_vld_p0_q;
    logic [31:0]       if_rdata_p0_q;

    function automatic logic acc_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'h0, w[7:0]};
            3'b101:  r = {16'h0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign bus.d_ready  = rst_n;
    assign bus.if_ready = rst_n & ~bus.d_req;
    assign d_acc        = rst_n & bus.d_req;
    assign if_acc       = rst_n & bus.if_req & ~bus.d_req;
    assign d_err_c      = acc_err(bus.d_we, bus.d_funct3, bus.d_addr[1:0]);

    // The single array port is steered to whichever request wins arbitration.
    assign rd_addr = bus.d_req ? bus.d_addr : {bus.if_addr[ADDR_W-1:2], 2'b00};
    assign rd_word = {mem[rd_addr + ADDR_W'(3)], mem[rd_addr + ADDR_W'(2)],
                      mem[rd_addr + ADDR_W'(1)], mem[rd_addr]};

    always_comb begin
        d_rdata_d = '0;
        if (d_acc && !bus.d_we && !d_err_c) d_rdata_d = load_ext(bus.d_funct3, rd_word);
        cnt_d = cnt_q;
        if (bus.if_req && bus.d_req) cnt_d = sat_inc(cnt_q);
    end

    // Contents survive reset; writes are gated by rst_n through d_acc.
    always_ff @(posedge clk) begin
        if (d_acc && bus.d_we && !d_err_c) begin
            mem[bus.d_addr] <= bus.d_wdata[7:0];
            if (bus.d_funct3[1:0] != 2'b00) mem[bus.d_addr + ADDR_W'(1)] <= bus.d_wdata[15:8];
            if (bus.d_funct3[1]) begin
                mem[bus.d_addr + ADDR_W'(2)] <= bus.d_wdata[23:16];
                mem[bus.d_addr + ADDR_W'(3)] <= bus.d_wdata[31:24];
            end
        end
    end

    // Stage p0: response captured on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_vld_p0_q    <= 1'b0;
            d_err_p0_q    <= 1'b0;
            d_rdata_p0_q  <= '0;
            if_vld_p0_q   <= 1'b0;
            if_rdata_p0_q <= '0;
            cnt_q         <= '0;
        end else begin
            d_vld_p0_q    <= d_acc;
            d_err_p0_q    <= d_acc & d_err_c;
            d_rdata_p0_q  <= d_rdata_d;
            if_vld_p0_q   <= if_acc;
            if_rdata_p0_q <= if_acc ? rd_word : '0;
            cnt_q         <= cnt_d;
        end
    end

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic        d_vld_p1_q;
            logic        d_err_p1_q;
            logic [31:0] d_rdata_p1_q;
            logic        if_vld_p1_q;
            logic [31:0] if_rdata_p1_q;

            // Stage p1: extra register slice for the two-cycle configuration.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_vld_p1_q    <= 1'b0;
                    d_err_p1_q    <= 1'b0;
                    d_rdata_p1_q  <= '0;
                    if_vld_p1_q   <= 1'b0;
                    if_rdata_p1_q <= '0;
                end else begin
                    d_vld_p1_q    <= d_vld_p0_q;
                    d_err_p1_q    <= d_err_p0_q;
                    d_rdata_p1_q  <= d_rdata_p0_q;
                    if_vld_p1_q   <= if_vld_p0_q;
                    if_rdata_p1_q <= if_rdata_p0_q;
                end
            end

            assign bus.d_valid  = d_vld_p1_q;
            assign bus.d_err    = d_err_p1_q;
            assign bus.d_rdata  = d_rdata_p1_q;
            assign bus.if_valid = if_vld_p1_q;
            assign bus.if_rdata = if_rdata_p1_q;
        end else begin : g_lat1
            assign bus.d_valid  = d_vld_p0_q;
            assign bus.d_err    = d_err_p0_q;
            assign bus.d_rdata  = d_rdata_p0_q;
            assign bus.if_valid = if_vld_p0_q;
            assign bus.if_rdata = if_rdata_p0_q;
        end
    endgenerate

    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_unified_mem_pipe.sv
// Scoreboard bench: two instances (READ_LAT=1/CNT_W=4 and READ_LAT=2/CNT_W=16) get identical
// stimulus; a byte-array model predicts every response, popped by a negedge monitor.
`timescale 1ns/1ps
module tb_unified_mem_pipe;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_f3 = 3'b0;
    logic [7:0]  d_addr = 8'h0;
    logic [31:0] d_wdata = 32'h0;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt_model = 0;
    logic [7:0]  mm [256];
    exp_t        dq1[$], dq2[$], fq1[$], fq2[$];

    unified_mem_if #(.ADDR_W(8), .CNT_W(4))  b1();
    unified_mem_if #(.ADDR_W(8), .CNT_W(16)) b2();

    assign b1.if_req = if_req;   assign b2.if_req = if_req;
    assign b1.if_addr = if_addr; assign b2.if_addr = if_addr;
    assign b1.d_req = d_req;     assign b2.d_req = d_req;
    assign b1.d_we = d_we;       assign b2.d_we = d_we;
    assign b1.d_funct3 = d_f3;   assign b2.d_funct3 = d_f3;
    assign b1.d_addr = d_addr;   assign b2.d_addr = d_addr;
    assign b1.d_wdata = d_wdata; assign b2.d_wdata = d_wdata;

    unified_mem_pipe #(.ADDR_W(8), .READ_LAT(1), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    unified_mem_pipe #(.ADDR_W(8), .READ_LAT(2), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic port_chk(input string nm, input logic vld, input logic [31:0] rd, input logic err,
                            input logic use_err, input int qsz, input exp_t hd, output logic pop);
        logic ev;
        ev = (qsz > 0) && (hd.due <= cyc);
        chk({nm, "_valid"}, 32'(vld), 32'(ev));
        pop = ev || (vld && qsz > 0);
        if (vld && qsz > 0) begin
            chk({nm, "_rdata"}, rd, hd.rdata);
            chk({nm, "_cycle"}, 32'(cyc), 32'(hd.due));
            if (use_err) chk({nm, "_err"}, 32'(err), 32'(hd.err));
        end
    endtask

    // Reference model: evaluated once per rising edge with the inputs that edge sees.
    task automatic model_edge(input int k);
        exp_t        e;
        int          sz;
        int          v;
        logic        legal;
        logic [7:0]  a;
        if (!rst_n) begin
            cnt_model = 0;
            return;
        end
        if (d_req && if_req) cnt_model++;
        if (d_req) begin
            sz = 1 << d_f3[1:0];
            legal = d_we ? (d_f3 <= 3'd2) : (d_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            e.err = !legal || ((int'(d_addr) % sz) != 0);
            e.rdata = 32'h0;
            if (!e.err) begin
                if (d_we) begin
                    for (int i = 0; i < sz; i++) mm[(int'(d_addr) + i) % 256] = d_wdata[8*i +: 8];
                end else begin
                    v = 0;
                    for (int i = 0; i < sz; i++) v = v | (int'(mm[(int'(d_addr) + i) % 256]) << (8 * i));
                    if (!d_f3[2] && sz < 4 && v >= (1 << (8 * sz - 1))) v = v - (1 << (8 * sz));
                    e.rdata = 32'(v);
                end
            end
            e.due = k + 1; dq1.push_back(e);
            e.due = k + 2; dq2.push_back(e);
        end else if (if_req) begin
            a = {if_addr[7:2], 2'b00};
            e.err = 1'b0;
            e.rdata = {mm[a + 8'd3], mm[a + 8'd2], mm[a + 8'd1], mm[a]};
            e.due = k + 1; fq1.push_back(e);
            e.due = k + 2; fq2.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(cyc);
        #2;
    endtask

    task automatic d_op(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = a; d_wdata = wd;
        tick();
        d_req = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t hd;
        exp_t none;
        logic p;
        none.rdata = 32'h0; none.err = 1'b0; none.due = 0;
        if (!rst_n) begin
            chk("rst_ctl1", 32'({b1.if_valid, b1.d_valid, b1.d_err, b1.if_ready, b1.d_ready}), 32'h0);
            chk("rst_ctl2", 32'({b2.if_valid, b2.d_valid, b2.d_err, b2.if_ready, b2.d_ready}), 32'h0);
            chk("rst_drd1", b1.d_rdata, 32'h0);  chk("rst_frd1", b1.if_rdata, 32'h0);
            chk("rst_drd2", b2.d_rdata, 32'h0);  chk("rst_frd2", b2.if_rdata, 32'h0);
            chk("rst_cnt1", 32'(b1.conflict_cnt), 32'h0);
            chk("rst_cnt2", 32'(b2.conflict_cnt), 32'h0);
        end else begin
            chk("d_ready1", 32'(b1.d_ready), 32'd1);
            chk("if_ready1", 32'(b1.if_ready), 32'(!d_req));
            chk("if_ready2", 32'(b2.if_ready), 32'(!d_req));
            chk("cnt1", 32'(b1.conflict_cnt), 32'(cnt_model > 15 ? 15 : cnt_model));
            chk("cnt2", 32'(b2.conflict_cnt), 32'(cnt_model > 65535 ? 65535 : cnt_model));
            hd = (dq1.size() > 0) ? dq1[0] : none;
            port_chk("d1", b1.d_valid, b1.d_rdata, b1.d_err, 1'b1, dq1.size(), hd, p);
            if (p) void'(dq1.pop_front());
            hd = (dq2.size() > 0) ? dq2[0] : none;
            port_chk("d2", b2.d_valid, b2.d_rdata, b2.d_err, 1'b1, dq2.size(), hd, p);
            if (p) void'(dq2.pop_front());
            hd = (fq1.size() > 0) ? fq1[0] : none;
            port_chk("f1", b1.if_valid, b1.if_rdata, 1'b0, 1'b0, fq1.size(), hd, p);
            if (p) void'(fq1.pop_front());
            hd = (fq2.size() > 0) ? fq2[0] : none;
            port_chk("f2", b2.if_valid, b2.if_rdata, 1'b0, 1'b0, fq2.size(), hd, p);
            if (p) void'(fq2.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests held high during reset must not be accepted.
        d_req = 1'b1; if_req = 1'b1; d_we = 1'b1;
        repeat (3) tick();
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;

        for (int a = 0; a < 256; a += 4) d_op(1'b1, 3'b010, 8'(a), $urandom);

        d_op(1'b1, 3'b010, 8'd0, 32'd17);
        d_op(1'b1, 3'b010, 8'd4, 32'd9);
        d_op(1'b1, 3'b010, 8'd8, 32'd25);
        d_op(1'b0, 3'b010, 8'd0, 32'h0);
        d_op(1'b0, 3'b010, 8'd4, 32'h0);
        d_op(1'b0, 3'b010, 8'd8, 32'h0);

        d_op(1'b1, 3'b010, 8'd12, 32'h8000_00A5);
        d_op(1'b0, 3'b000, 8'd12, 32'h0);
        d_op(1'b0, 3'b100, 8'd12, 32'h0);
        d_op(1'b0, 3'b001, 8'd12, 32'h0);
        d_op(1'b0, 3'b101, 8'd14, 32'h0);

        // Fetch blocked for three cycles, accepted on the fourth.
        if_addr = 8'h0A; if_req = 1'b1;
        repeat (3) d_op(1'b0, 3'b010, 8'd4, 32'h0);
        tick();
        if_req = 1'b0;

        d_op(1'b0, 3'b010, 8'd6, 32'h0);
        d_op(1'b1, 3'b001, 8'd13, 32'hFFFF_FFFF);
        d_op(1'b0, 3'b011, 8'd0, 32'h0);
        d_op(1'b0, 3'b010, 8'd12, 32'h0);

        for (int i = 0; i < 400; i++) begin
            d_req = ($urandom_range(0, 2) != 0);
            if_req = 1'($urandom_range(0, 1));
            d_we = 1'($urandom_range(0, 1));
            d_f3 = 3'($urandom_range(0, 7));
            d_addr = 8'($urandom);
            if ($urandom_range(0, 3) != 0) d_addr = d_addr & ~8'((1 << d_f3[1:0]) - 1);
            d_wdata = $urandom;
            if_addr = 8'($urandom);
            tick();
        end
        d_req = 1'b0; if_req = 1'b0;

        if_req = 1'b1;
        repeat (20) d_op(1'b0, 3'b010, 8'd0, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        chk("cnt_saturated", 32'(b1.conflict_cnt), 32'd15);
        #2;

        // Two loads in flight when reset hits.
        d_op(1'b0, 3'b010, 8'd12, 32'h0);
        d_op(1'b0, 3'b010, 8'd0, 32'h0);
        rst_n = 1'b0;
        cnt_model = 0;
        dq1.delete(); dq2.delete(); fq1.delete(); fq2.delete();
        d_req = 1'b1; d_we = 1'b1; d_f3 = 3'b010; d_addr = 8'd12; if_req = 1'b1;
        repeat (3) tick();
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
        rst_n = 1'b1;
        d_op(1'b0, 3'b010, 8'd12, 32'h0);
        d_op(1'b0, 3'b010, 8'd0, 32'h0);
        if_addr = 8'h04; if_req = 1'b1;
        tick();
        if_req = 1'b0;
        repeat (5) tick();

        chk("dq1_drained", 32'(dq1.size()), 32'd0);
        chk("dq2_drained", 32'(dq2.size()), 32'd0);
        chk("fq1_drained", 32'(fq1.size()), 32'd0);
        chk("fq2_drained", 32'(fq2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
